// File: rtl/multi_wave_dds.sv
// Multi-channel DDS: per-channel phase accumulator with shadowed config applied at wrap.
// Optional SYNC_START_EN adds a sync_start input that zeroes all accumulators at once.
module multi_wave_dds #(
    parameter int CH_NUM = 2,
    parameter int DW     = 8,
    parameter int PW     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_wr,
    input  logic [2:0]           cfg_ch,
    input  logic [PW-1:0]        cfg_freq_word,
    input  logic [PW-1:0]        cfg_phase,
    input  logic [DW:0]          cfg_amp,
    input  logic [1:0]           cfg_mode,
`ifdef SYNC_START_EN
    input  logic                 sync_start,
`endif
    output logic                 cfg_ack,
    output logic [CH_NUM-1:0]    cfg_pending,
    output logic [CH_NUM*DW-1:0] wave_out,
    output logic                 wave_valid,
    output logic [CH_NUM-1:0]    wrap_pulse
);

    localparam logic [DW:0] AMP_UNITY = {1'b1, {DW{1'b0}}};

    logic          sync_clr;
    logic          en_d1;
    logic          en_d2;
    logic          ack_q;
    logic [DW:0]   amp_sat;

`ifdef SYNC_START_EN
    assign sync_clr = sync_start;
`else
    assign sync_clr = 1'b0;
`endif

    assign amp_sat = (cfg_amp > AMP_UNITY) ? AMP_UNITY : cfg_amp;

    // wave_valid has no ready: each cycle it is high, wave_out carries one new sample
    // (the sample of the accumulator value two cycles earlier); no back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d1 <= 1'b0;
            en_d2 <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            en_d1 <= en;
            en_d2 <= en_d1;
            ack_q <= cfg_wr;
        end
    end

    assign wave_valid = en_d2;
    assign cfg_ack    = ack_q;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [PW-1:0] acc;
        logic [PW-1:0] act_freq;
        logic [PW-1:0] act_phase;
        logic [DW:0]   act_amp;
        logic [1:0]    act_mode;
        logic [PW-1:0] sh_freq;
        logic [PW-1:0] sh_phase;
        logic [DW:0]   sh_amp;
        logic [1:0]    sh_mode;
        logic          pend;
        logic          wrap_q;
        logic [PW:0]   sum;
        logic          wr_hit;
        logic          apply;
        logic [PW-1:0] p;
        logic [DW-1:0] raw;
        logic [DW-1:0] raw_q;
        logic [DW:0]   amp_q;
        logic [DW-1:0] out_q;
        logic [2*DW:0] prod;
        logic          unused_bits;

        assign sum    = {1'b0, acc} + {1'b0, act_freq};
        assign wr_hit = cfg_wr && (cfg_ch == 3'(i));
        // A stopped channel (en low or zero step) never wraps, so it takes pending config at once.
        assign apply  = pend && (sync_clr || !en || sum[PW] || (act_freq == '0));
        assign p      = acc + act_phase;

        always_comb begin
            raw = '0;
            case (act_mode)
                2'd0:    raw = p[PW-1 -: DW];
                2'd1:    raw = p[PW-1] ? ~p[PW-2 -: DW] : p[PW-2 -: DW];
                2'd2:    raw = p[PW-1] ? '0 : '1;
                default: raw = '1;
            endcase
        end

        assign prod        = {{(DW+1){1'b0}}, raw_q} * {{DW{1'b0}}, amp_q};
        assign unused_bits = ^{p, prod};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc       <= '0;
                act_freq  <= '0;
                act_phase <= '0;
                act_amp   <= '0;
                act_mode  <= '0;
                sh_freq   <= '0;
                sh_phase  <= '0;
                sh_amp    <= '0;
                sh_mode   <= '0;
                pend      <= 1'b0;
                wrap_q    <= 1'b0;
                raw_q     <= '0;
                amp_q     <= '0;
                out_q     <= '0;
            end else begin
                if (sync_clr) begin
                    acc    <= '0;
                    wrap_q <= 1'b0;
                end else if (en) begin
                    acc    <= sum[PW-1:0];
                    wrap_q <= sum[PW];
                end else begin
                    wrap_q <= 1'b0;
                end

                if (apply) begin
                    act_freq  <= sh_freq;
                    act_phase <= sh_phase;
                    act_amp   <= sh_amp;
                    act_mode  <= sh_mode;
                end

                // A write racing an apply lands after it, so pending stays set.
                if (wr_hit) begin
                    sh_freq  <= cfg_freq_word;
                    sh_phase <= cfg_phase;
                    sh_amp   <= amp_sat;
                    sh_mode  <= cfg_mode;
                    pend     <= 1'b1;
                end else if (apply) begin
                    pend <= 1'b0;
                end

                if (en) begin
                    raw_q <= raw;
                    amp_q <= act_amp;
                end
                if (en_d1) begin
                    out_q <= prod[2*DW-1:DW];
                end
            end
        end

        assign wave_out[i*DW +: DW] = out_q;
        assign cfg_pending[i]       = pend;
        assign wrap_pulse[i]        = wrap_q;
    end

endmodule
